// File: rtl/div_if.sv
// Handshake and result bundle between the Execute-stage control and the divider.
interface div_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic             signed_div;
   logic             annul;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             stall_div;
   logic             ready;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, signed_div, annul, a, b,
      input  stall_div, ready, hi, lo
   );

   modport slave (
      input  start, signed_div, annul, a, b,
      output stall_div, ready, hi, lo
   );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider for MIPS DIV/DIVU; one quotient bit per cycle, result into HI/LO.
module div_unit #(
   parameter int WIDTH = 32
) (
   input  logic  clk,
   input  logic  rst,
   div_if.slave  bus
);
   localparam int CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state, stateNext;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] rem, quo, absB;
   logic             negQuo, negRem;
   logic [WIDTH:0]   remShift, trial;
   logic [WIDTH-1:0] remNext, quoNext;
   logic             takeStart, lastIter, divZero;

   function automatic logic [WIDTH-1:0] condNeg(input logic [WIDTH-1:0] v, input logic neg);
      return neg ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
   endfunction

   function automatic logic [WIDTH-1:0] absVal(input logic signed [WIDTH-1:0] v, input logic isSigned);
      return condNeg(v, isSigned && (v < 0));
   endfunction

   assign takeStart = (state == IDLE) && bus.start && !bus.annul;
   assign lastIter  = (state == BUSY) && (cnt == CNT_W'(1));
   assign divZero   = (bus.b == '0);

   // trial[WIDTH] is the exact sign: rem < |b| guarantees a non-negative trial is below |b|
   assign remShift = {rem, quo[WIDTH-1]};
   assign trial    = remShift - {1'b0, absB};
   assign remNext  = trial[WIDTH] ? remShift[WIDTH-1:0] : trial[WIDTH-1:0];
   assign quoNext  = {quo[WIDTH-2:0], ~trial[WIDTH]};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      unique case (state)
         IDLE: if (takeStart) stateNext = divZero ? DONE : BUSY;
         BUSY: begin
            if (bus.annul)    stateNext = IDLE;
            else if (lastIter) stateNext = DONE;
         end
         DONE:    stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt    <= '0;
         rem    <= '0;
         quo    <= '0;
         absB   <= '0;
         negQuo <= 1'b0;
         negRem <= 1'b0;
         bus.hi <= '0;
         bus.lo <= '0;
      end else if (takeStart) begin
         rem    <= '0;
         quo    <= absVal(bus.a, bus.signed_div);
         absB   <= absVal(bus.b, bus.signed_div);
         cnt    <= CNT_W'(WIDTH);
         negQuo <= bus.signed_div && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
         negRem <= bus.signed_div && bus.a[WIDTH-1];
         // Divide by zero bypasses the iteration: raw dividend, no sign fix-up
         if (divZero) begin
            bus.lo <= '1;
            bus.hi <= bus.a;
         end
      end else if ((state == BUSY) && !bus.annul) begin
         rem <= remNext;
         quo <= quoNext;
         cnt <= cnt - CNT_W'(1);
         if (lastIter) begin
            bus.lo <= condNeg(quoNext, negQuo);
            bus.hi <= condNeg(remNext, negRem);
         end
      end
   end

   assign bus.ready     = (state == DONE);
   assign bus.stall_div = rst && (takeStart || (state == BUSY));
endmodule
